cell_pos_pingpong: RTL and testbench

//  Double-buffered per-cell particle position store; successor to the single-port fixed-init cell RAM.

---
 rtl/cell_pos_pingpong.sv | 167 ++++++++++++++++
 tb/tb_cell_pos_pingpong.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_pos_pingpong.sv
`default_nettype none
// =============================================================================
// cell_pos_pingpong : double-buffered per-cell particle position store
// Rev 1.0
// =============================================================================
module cell_pos_pingpong #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic                  clock_i,
    input  logic                  rst_n,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rd_ready_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  wr_valid_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_ready_o,
    input  logic                  swap_req_i,
    output logic                  swap_done_o,
    output logic [ADDR_WIDTH-1:0] active_cnt_o,
    output logic                  overflow_o
);

    localparam int                  C_DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] C_FULL_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_SWAP  = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    bank_q;
    logic [ADDR_WIDTH-1:0]   act_cnt_q;
    logic [ADDR_WIDTH-1:0]   shd_cnt_q;
    logic                    ovf_q;
    logic                    swap_done_q;

    logic                    s1_vld_q;
    logic [ADDR_WIDTH-1:0]   s1_addr_q;
    logic                    s1_zero_q;
    logic                    s1_oob_q;
    logic [ADDR_WIDTH-1:0]   s1_cnt_q;

    logic                    s2_vld_q;
    logic                    s2_zero_q;
    logic                    s2_oob_q;
    logic [ADDR_WIDTH-1:0]   s2_cnt_q;
    logic                    s2_bank_q;

    logic [DATA_WIDTH-1:0]   mem0_q [C_DEPTH];
    logic [DATA_WIDTH-1:0]   mem1_q [C_DEPTH];
    logic [DATA_WIDTH-1:0]   ram0_q;
    logic [DATA_WIDTH-1:0]   ram1_q;

    logic                    w_full;
    logic                    w_wr_fire;
    logic                    w_rd_fire;
    logic [ADDR_WIDTH-1:0]   w_waddr;

    assign w_full     = (shd_cnt_q == C_FULL_CNT);
    assign wr_ready_o = !w_full && (state_q == S_IDLE);
    assign rd_ready_o = (state_q == S_IDLE);
    assign w_wr_fire  = wr_valid_i && wr_ready_o;
    assign w_rd_fire  = rd_en_i && rd_ready_o;
    assign w_waddr    = shd_cnt_q + 1'b1;

    assign swap_done_o  = swap_done_q;
    assign active_cnt_o = act_cnt_q;
    assign overflow_o   = ovf_q;
    assign rd_valid_o   = s2_vld_q;

    // Unreset storage: the shadow bank is always the one not being read.
    always_ff @(posedge clock_i) begin
        if (w_wr_fire && bank_q) begin
            mem0_q[w_waddr] <= wr_data_i;
        end
        if (w_wr_fire && !bank_q) begin
            mem1_q[w_waddr] <= wr_data_i;
        end
        ram0_q <= mem0_q[s1_addr_q];
        ram1_q <= mem1_q[s1_addr_q];
    end

    always_comb begin
        rd_data_o = '0;
        if (s2_vld_q) begin
            if (s2_zero_q) begin
                rd_data_o = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, s2_cnt_q};
            end else if (!s2_oob_q) begin
                rd_data_o = s2_bank_q ? ram1_q : ram0_q;
            end
        end
    end

    always_ff @(posedge clock_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bank_q      <= 1'b0;
            act_cnt_q   <= '0;
            shd_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            swap_done_q <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_addr_q   <= '0;
            s1_zero_q   <= 1'b0;
            s1_oob_q    <= 1'b0;
            s1_cnt_q    <= '0;
            s2_vld_q    <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_oob_q    <= 1'b0;
            s2_cnt_q    <= '0;
            s2_bank_q   <= 1'b0;
        end else begin
            // Read pipeline: stage 1 addresses the RAM, stage 2 presents data.
            s1_vld_q    <= w_rd_fire;
            s1_addr_q   <= rd_addr_i;
            s1_zero_q   <= (rd_addr_i == '0);
            s1_oob_q    <= (rd_addr_i > act_cnt_q);
            s1_cnt_q    <= act_cnt_q;
            s2_vld_q    <= s1_vld_q;
            s2_zero_q   <= s1_zero_q;
            s2_oob_q    <= s1_oob_q;
            s2_cnt_q    <= s1_cnt_q;
            s2_bank_q   <= bank_q;
            swap_done_q <= 1'b0;

            if (w_wr_fire) begin
                shd_cnt_q <= w_waddr;
            end
            if (wr_valid_i && w_full) begin
                ovf_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (swap_req_i) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Stage 2 still reads the captured bank, so only stage 1 blocks.
                    if (!s1_vld_q) begin
                        state_q     <= S_SWAP;
                        swap_done_q <= 1'b1;
                    end
                end
                S_SWAP: begin
                    state_q   <= S_IDLE;
                    bank_q    <= !bank_q;
                    act_cnt_q <= shd_cnt_q;
                    shd_cnt_q <= '0;
                    ovf_q     <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cell_pos_pingpong.sv
`default_nettype none
// =============================================================================
// tb_cell_pos_pingpong : directed bench for the ping-pong position store
// Rev 1.0
// =============================================================================
module tb_cell_pos_pingpong;

    localparam int DW = 96;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          swap_req = 1'b0;
    logic          swap_done;
    logic [AW-1:0] active_cnt;
    logic          overflow;

    int n_total = 0;
    int n_bad   = 0;

    logic [AW-1:0] q_addr [8];
    logic [DW-1:0] q_exp  [8];

    localparam logic [DW-1:0] C_A = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1};
    localparam logic [DW-1:0] C_B = {32'h0000_00B3, 32'h0000_00B2, 32'h0000_00B1};
    localparam logic [DW-1:0] C_C = {32'h0000_00C3, 32'h0000_00C2, 32'h0000_00C1};
    localparam logic [DW-1:0] C_D = {32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001};
    localparam logic [DW-1:0] C_E = {32'hEEEE_0003, 32'hEEEE_0002, 32'hEEEE_0001};
    localparam logic [DW-1:0] C_X = {32'hBAD0_BAD0, 32'hBAD0_BAD0, 32'hBAD0_BAD0};

    cell_pos_pingpong #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .PARTICLE_NUM (220)
    ) u_dut (
        .clock_i      (clk),
        .rst_n        (rst_n),
        .rd_en_i      (rd_en),
        .rd_addr_i    (rd_addr),
        .rd_ready_o   (rd_ready),
        .rd_data_o    (rd_data),
        .rd_valid_o   (rd_valid),
        .wr_valid_i   (wr_valid),
        .wr_data_i    (wr_data),
        .wr_ready_o   (wr_ready),
        .swap_req_i   (swap_req),
        .swap_done_o  (swap_done),
        .active_cnt_o (active_cnt),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] fill_word(input int j);
        return {32'hF000_0000 | 32'(j), 32'(j), ~32'(j)};
    endfunction

    task automatic chk_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams n reads back-to-back, optionally appending one word in the first cycle.
    task automatic run_reads(input int n, input string tag, input bit do_wr, input logic [DW-1:0] wword);
        for (int k = 0; k < n + 2; k++) begin
            rd_en    = (k < n);
            rd_addr  = (k < n) ? q_addr[k] : '0;
            wr_valid = do_wr && (k == 0);
            wr_data  = wword;
            if (k >= 2) begin
                chk_eq($sformatf("%s_valid%0d", tag, k - 2), DW'(rd_valid), DW'(1'b1));
                chk_eq($sformatf("%s_data%0d", tag, k - 2), rd_data, q_exp[k - 2]);
            end
            step();
        end
        rd_en    = 1'b0;
        wr_valid = 1'b0;
        chk_eq({tag, "_idle"}, DW'(rd_valid), DW'(1'b0));
    endtask

    task automatic do_swap_min(input string tag);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        chk_eq({tag, "_done_t1"}, DW'(swap_done), DW'(1'b0));
        step();
        chk_eq({tag, "_done_t2"}, DW'(swap_done), DW'(1'b1));
        step();
        chk_eq({tag, "_done_t3"}, DW'(swap_done), DW'(1'b0));
    endtask

    initial begin
        // 1: reset values and count read
        step();
        step();
        chk_eq("rst_rd_valid", DW'(rd_valid), '0);
        chk_eq("rst_rd_data", rd_data, '0);
        chk_eq("rst_swap_done", DW'(swap_done), '0);
        chk_eq("rst_overflow", DW'(overflow), '0);
        chk_eq("rst_active_cnt", DW'(active_cnt), '0);
        chk_eq("rst_rd_ready", DW'(rd_ready), DW'(1'b1));
        chk_eq("rst_wr_ready", DW'(wr_ready), DW'(1'b1));
        rst_n = 1'b1;
        step();
        rd_en = 1'b1;
        rd_addr = '0;
        step();
        rd_en = 1'b0;
        chk_eq("t1_valid_t1", DW'(rd_valid), '0);
        step();
        chk_eq("t1_valid_t2", DW'(rd_valid), DW'(1'b1));
        chk_eq("t1_data_t2", rd_data, '0);
        step();

        // 2: append A,B,C then swap
        wr_valid = 1'b1;
        wr_data = C_A; step();
        wr_data = C_B; step();
        wr_data = C_C; step();
        wr_valid = 1'b0;
        do_swap_min("t2");
        chk_eq("t2_active_cnt", DW'(active_cnt), DW'(3));
        q_addr[0] = 8'd0; q_exp[0] = DW'(3);
        q_addr[1] = 8'd1; q_exp[1] = C_A;
        q_addr[2] = 8'd2; q_exp[2] = C_B;
        q_addr[3] = 8'd3; q_exp[3] = C_C;
        q_addr[4] = 8'd4; q_exp[4] = '0;
        run_reads(5, "t2_rd", 1'b0, '0);

        // 3: streaming reads while appending D into the shadow bank
        q_addr[0] = 8'd1; q_exp[0] = C_A;
        q_addr[1] = 8'd2; q_exp[1] = C_B;
        q_addr[2] = 8'd3; q_exp[2] = C_C;
        run_reads(3, "t3_rd", 1'b1, C_D);
        chk_eq("t3_active_cnt", DW'(active_cnt), DW'(3));

        // 4: fill shadow to 219 and overflow it
        wr_valid = 1'b1;
        for (int j = 2; j <= 219; j++) begin
            wr_data = fill_word(j);
            step();
        end
        chk_eq("t4_wr_ready_full", DW'(wr_ready), '0);
        chk_eq("t4_ovf_before", DW'(overflow), '0);
        wr_data = C_X;
        step();
        wr_valid = 1'b0;
        chk_eq("t4_ovf_set", DW'(overflow), DW'(1'b1));
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        step();
        chk_eq("t4_swap_done", DW'(swap_done), DW'(1'b1));
        chk_eq("t4_ovf_hold", DW'(overflow), DW'(1'b1));
        step();
        chk_eq("t4_ovf_clear", DW'(overflow), '0);
        chk_eq("t4_active_cnt", DW'(active_cnt), DW'(219));
        chk_eq("t4_wr_ready_new", DW'(wr_ready), DW'(1'b1));
        q_addr[0] = 8'd0;   q_exp[0] = DW'(219);
        q_addr[1] = 8'd1;   q_exp[1] = C_D;
        q_addr[2] = 8'd2;   q_exp[2] = fill_word(2);
        q_addr[3] = 8'd219; q_exp[3] = fill_word(219);
        q_addr[4] = 8'd220; q_exp[4] = '0;
        run_reads(5, "t4_rd", 1'b0, '0);

        // 5: read and swap request in the same cycle
        rd_en = 1'b1;
        rd_addr = 8'd1;
        swap_req = 1'b1;
        step();
        rd_en = 1'b0;
        swap_req = 1'b0;
        chk_eq("t5_rd_ready_t1", DW'(rd_ready), '0);
        chk_eq("t5_valid_t1", DW'(rd_valid), '0);
        chk_eq("t5_done_t1", DW'(swap_done), '0);
        step();
        chk_eq("t5_valid_t2", DW'(rd_valid), DW'(1'b1));
        chk_eq("t5_data_t2", rd_data, C_D);
        chk_eq("t5_done_t2", DW'(swap_done), '0);
        step();
        chk_eq("t5_done_t3", DW'(swap_done), DW'(1'b1));
        step();
        chk_eq("t5_done_t4", DW'(swap_done), '0);
        chk_eq("t5_active_cnt", DW'(active_cnt), '0);
        q_addr[0] = 8'd0; q_exp[0] = '0;
        q_addr[1] = 8'd1; q_exp[1] = '0;
        run_reads(2, "t5_rd", 1'b0, '0);

        // 6: reset asserted while draining with a read in flight
        wr_valid = 1'b1;
        wr_data = C_E;
        step();
        wr_valid = 1'b0;
        rd_en = 1'b1;
        rd_addr = 8'd1;
        swap_req = 1'b1;
        step();
        rd_en = 1'b0;
        swap_req = 1'b0;
        chk_eq("t6_draining", DW'(rd_ready), '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("t6_rst_rd_ready", DW'(rd_ready), DW'(1'b1));
        chk_eq("t6_rst_wr_ready", DW'(wr_ready), DW'(1'b1));
        chk_eq("t6_rst_active_cnt", DW'(active_cnt), '0);
        chk_eq("t6_rst_swap_done", DW'(swap_done), '0);
        chk_eq("t6_rst_overflow", DW'(overflow), '0);
        step();
        chk_eq("t6_rst_valid", DW'(rd_valid), '0);
        chk_eq("t6_rst_data", rd_data, '0);
        rst_n = 1'b1;
        step();
        chk_eq("t6_no_done", DW'(swap_done), '0);
        step();
        chk_eq("t6_idle", DW'(rd_ready), DW'(1'b1));
        q_addr[0] = 8'd0; q_exp[0] = '0;
        q_addr[1] = 8'd1; q_exp[1] = '0;
        run_reads(2, "t6_rd", 1'b0, '0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
